// File: rtl/byte_decode_gearbox.sv
// ByteDecode_d gearbox: IW-bit byte words in, NC 12-bit coefficient lanes per beat out; beat valid 1 cycle after its last word,
// input ready drops when the bit buffer cannot take a word. Optional MODQ_CHECK_EN adds per-lane >= 3329 flags for d==12.
module byte_decode_gearbox #(
   parameter int IW = 64,
   parameter int NC = 4,
   parameter int N  = 256
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [3:0]       i_l,
   input  logic [IW-1:0]    i_ibytes,
   input  logic             i_ibytes_valid,
   output logic             o_ibytes_ready,
   output logic [NC*12-1:0] o_coeffs,
   output logic             o_coeffs_valid,
   input  logic             i_coeffs_ready,
   output logic             o_done,
   output logic             o_err,
   output logic [NC-1:0]    o_modq_flag
);

   localparam int BUF_W = IW + NC*12;
   localparam int FW    = $clog2(BUF_W + 1);
   localparam int CW    = $clog2(N*12/8 + 1);
   localparam int B     = N / NC;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t            state;
   logic [3:0]        d;
   logic [BUF_W-1:0]  bbuf;
   logic [FW-1:0]     fill;
   logic [CW-1:0]     word_cnt;
   logic [CW-1:0]     beat_cnt;
   logic [CW-1:0]     word_tgt;

   logic              active;
   logic              pop;
   logic              push;
   logic              beat_acc;
   logic [FW-1:0]     pop_bits;
   logic [FW-1:0]     fill_after;
   logic [FW-1:0]     fill_next;
   logic [BUF_W-1:0]  buf_after;
   logic [BUF_W-1:0]  buf_next;
   logic [11:0]       lane_mask;
   logic [NC*12-1:0]  lane_next;

   function automatic logic legal_d(input logic [3:0] v);
      return v inside {4'd1, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12};
   endfunction

   always_comb begin
      active     = (state == S_RUN) || (state == S_DRAIN);
      pop_bits   = FW'(NC * int'(d));
      pop        = active && (fill >= pop_bits) && (!o_coeffs_valid || i_coeffs_ready);
      fill_after = pop ? fill - pop_bits : fill;
      // Ready looks at the post-pop fill so a word can enter in the same cycle a beat leaves.
      o_ibytes_ready = (state == S_RUN) && (int'(fill_after) + IW <= BUF_W);
      push       = o_ibytes_ready && i_ibytes_valid;
      buf_after  = pop ? (bbuf >> pop_bits) : bbuf;
      buf_next   = push ? (buf_after | (BUF_W'(i_ibytes) << fill_after)) : buf_after;
      fill_next  = push ? fill_after + FW'(IW) : fill_after;
      beat_acc   = o_coeffs_valid && i_coeffs_ready;
      lane_mask  = 12'((13'd1 << d) - 13'd1);
      lane_next  = '0;
      for (int k = 0; k < NC; k++) begin
         lane_next[12*k +: 12] = 12'(bbuf >> (k * int'(d))) & lane_mask;
      end
   end

`ifdef MODQ_CHECK_EN
   logic [NC-1:0] modq_next;

   always_comb begin
      modq_next = '0;
      for (int k = 0; k < NC; k++) begin
         modq_next[k] = (d == 4'd12) && (lane_next[12*k +: 12] >= 12'd3329);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_modq_flag <= '0;
      end else if (pop) begin
         o_modq_flag <= modq_next;
      end
   end
`else
   assign o_modq_flag = '0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state          <= S_IDLE;
         d              <= '0;
         bbuf           <= '0;
         fill           <= '0;
         word_cnt       <= '0;
         beat_cnt       <= '0;
         word_tgt       <= '0;
         o_coeffs       <= '0;
         o_coeffs_valid <= 1'b0;
         o_done         <= 1'b0;
         o_err          <= 1'b0;
      end else begin
         o_done <= 1'b0;
         o_err  <= 1'b0;
         bbuf   <= buf_next;
         fill   <= fill_next;

         if (pop) begin
            o_coeffs       <= lane_next;
            o_coeffs_valid <= 1'b1;
         end else if (i_coeffs_ready) begin
            o_coeffs_valid <= 1'b0;
         end

         if (push)     word_cnt <= word_cnt + 1'b1;
         if (beat_acc) beat_cnt <= beat_cnt + 1'b1;

         unique case (state)
            S_IDLE: begin
               if (i_start) begin
                  if (legal_d(i_l)) begin
                     d        <= i_l;
                     word_tgt <= CW'((N * int'(i_l)) / IW);
                     word_cnt <= '0;
                     beat_cnt <= '0;
                     state    <= S_RUN;
                  end else begin
                     o_err <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (push && (word_cnt + 1'b1 == word_tgt)) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (beat_acc && (beat_cnt + 1'b1 == CW'(B))) begin
                  state  <= S_DONE;
                  o_done <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_byte_decode_gearbox.sv
// Directed bench for byte_decode_gearbox (IW=64, NC=4, N=256); bit-serial reference model, MODQ_CHECK_EN aware.
module tb_byte_decode_gearbox;

   localparam int IW = 64;
   localparam int NC = 4;
   localparam int N  = 256;
   localparam int NB = N / NC;

   logic             i_clk = 1'b0;
   logic             i_rst = 1'b0;
   logic             i_start = 1'b0;
   logic [3:0]       i_l = '0;
   logic [IW-1:0]    i_ibytes = '0;
   logic             i_ibytes_valid = 1'b0;
   logic             o_ibytes_ready;
   logic [NC*12-1:0] o_coeffs;
   logic             o_coeffs_valid;
   logic             i_coeffs_ready = 1'b0;
   logic             o_done;
   logic             o_err;
   logic [NC-1:0]    o_modq_flag;

   byte_decode_gearbox #(.IW(IW), .NC(NC), .N(N)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_l(i_l),
      .i_ibytes(i_ibytes), .i_ibytes_valid(i_ibytes_valid), .o_ibytes_ready(o_ibytes_ready),
      .o_coeffs(o_coeffs), .o_coeffs_valid(o_coeffs_valid), .i_coeffs_ready(i_coeffs_ready),
      .o_done(o_done), .o_err(o_err), .o_modq_flag(o_modq_flag)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [IW-1:0] words[$];
   logic [11:0]   got[$];
   logic          got_flag[$];
   logic          timed_out;
   logic          done_ok;
   logic          done_low;
   int            fill_done;
   int            done_pulses;
   logic          stall_stable;
   logic          stall_drop;
   int            stall_cnt;

   always @(negedge i_clk) if (o_done) done_pulses++;

   function automatic logic [11:0] ref_coeff(input int dd, input int i);
      logic [11:0] c;
      int pos;
      c = '0;
      for (int b = 0; b < dd; b++) begin
         pos  = i*dd + b;
         c[b] = words[pos / IW][pos % IW];
      end
      return c;
   endfunction

   function automatic logic ref_flag(input int dd, input logic [11:0] c);
`ifdef MODQ_CHECK_EN
      return (dd == 12) && (c >= 12'd3329);
`else
      return 1'b0 & dd[0] & c[0];
`endif
   endfunction

   task automatic fill_random(input int nw);
      words.delete();
      for (int w = 0; w < nw; w++) words.push_back({$urandom, $urandom});
   endtask

   // Starts a poly, feeds words[] with random gaps, collects every lane of every accepted beat.
   task automatic run_poly(input int dd, input int nwords, input int gap_pct, input int rdy_pct, input int stall_at);
      got.delete();
      got_flag.delete();
      timed_out = 1'b0; done_ok = 1'b0; done_low = 1'b0; fill_done = -1;
      stall_stable = 1'b1; stall_drop = 1'b0; stall_cnt = 0; done_pulses = 0;
      @(posedge i_clk); #1;
      i_start = 1'b1; i_l = 4'(dd);
      @(posedge i_clk); #1;
      i_start = 1'b0;
      fork
         begin
            int w = 0;
            int cyc = 0;
            while (w < nwords && cyc < 4000) begin
               i_ibytes_valid = ($urandom_range(99) >= gap_pct);
               i_ibytes = words[w];
               @(negedge i_clk);
               if (i_ibytes_valid && o_ibytes_ready) w++;
               @(posedge i_clk); #1;
               cyc++;
            end
            i_ibytes_valid = 1'b0;
            if (w < nwords) timed_out = 1'b1;
         end
         begin
            int nb = 0;
            int cyc = 0;
            logic [NC*12-1:0] held;
            logic stalling;
            held = '0;
            while (nb < NB && cyc < 4000) begin
               stalling = (nb == stall_at) && (stall_cnt < 6);
               i_coeffs_ready = stalling ? 1'b0 : ($urandom_range(99) < rdy_pct);
               @(negedge i_clk);
               if (stalling) begin
                  if (o_coeffs_valid) begin
                     if (stall_cnt == 0) held = o_coeffs;
                     else if (o_coeffs !== held) stall_stable = 1'b0;
                     if (!o_ibytes_ready) stall_drop = 1'b1;
                     stall_cnt++;
                  end
               end else if (i_coeffs_ready && o_coeffs_valid) begin
                  for (int k = 0; k < NC; k++) begin
                     got.push_back(o_coeffs[12*k +: 12]);
                     got_flag.push_back(o_modq_flag[k]);
                  end
                  nb++;
               end
               if (nb < NB) begin
                  @(posedge i_clk); #1;
               end
               cyc++;
            end
            if (nb == NB) begin
               @(posedge i_clk); #1;
               i_coeffs_ready = 1'b0;
               @(negedge i_clk);
               done_ok   = o_done;
               fill_done = int'(dut.fill);
               @(negedge i_clk);
               done_low  = !o_done;
            end else begin
               timed_out = 1'b1;
            end
         end
      join
      i_coeffs_ready = 1'b0;
      repeat (3) @(negedge i_clk);
   endtask

   task automatic check_poly(input string name, input int dd);
      int bad;
      int bad_flag;
      bad = 0; bad_flag = 0;
      n_checks++;
      if (timed_out !== 1'b0) begin
         n_fail++; $display("FAIL %s timeout: got %0b want 0", name, timed_out);
      end
      n_checks++;
      if (got.size() !== N) begin
         n_fail++; $display("FAIL %s coeff count: got %0d want %0d", name, got.size(), N);
      end
      for (int i = 0; i < got.size(); i++) begin
         if (got[i] !== ref_coeff(dd, i)) bad++;
         if (got_flag[i] !== ref_flag(dd, got[i])) bad_flag++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++; $display("FAIL %s coeff data: %0d wrong lanes, want 0", name, bad);
      end
      n_checks++;
      if (bad_flag != 0) begin
         n_fail++; $display("FAIL %s modq flags: %0d wrong, want 0", name, bad_flag);
      end
      n_checks++;
      if (done_ok !== 1'b1 || done_low !== 1'b1 || done_pulses !== 1) begin
         n_fail++;
         $display("FAIL %s done pulse: after_last=%0b cleared=%0b pulses=%0d want 1 1 1", name, done_ok, done_low, done_pulses);
      end
      n_checks++;
      if (fill_done !== 0) begin
         n_fail++; $display("FAIL %s fill at done: got %0d want 0", name, fill_done);
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      n_checks++;
      if ({o_ibytes_ready, o_coeffs_valid, o_done, o_err} !== 4'b0) begin
         n_fail++; $display("FAIL reset ctrl: got %b want 0000", {o_ibytes_ready, o_coeffs_valid, o_done, o_err});
      end
      n_checks++;
      if (o_coeffs !== '0 || o_modq_flag !== '0) begin
         n_fail++; $display("FAIL reset data: coeffs=%h flags=%b want 0", o_coeffs, o_modq_flag);
      end
   endtask

   task automatic test_d12_bytes();
      fill_random(48);
      words[0][23:0] = 24'h452301;
      run_poly(12, 48, 0, 100, -1);
      n_checks++;
      if (got.size() < 2 || got[0] !== 12'h301 || got[1] !== 12'h452) begin
         n_fail++;
         $display("FAIL d12 first lanes: got %h %h want 301 452", got.size() > 0 ? got[0] : 12'hx, got.size() > 1 ? got[1] : 12'hx);
      end
      check_poly("d12", 12);
   endtask

   task automatic test_d1_ones();
      int bad;
      words.delete();
      for (int w = 0; w < 4; w++) words.push_back({IW{1'b1}});
      run_poly(1, 4, 0, 100, -1);
      bad = 0;
      for (int i = 0; i < got.size(); i++) if (got[i] !== 12'd1) bad++;
      n_checks++;
      if (got.size() !== N || bad != 0) begin
         n_fail++; $display("FAIL d1 ones: count=%0d nonone=%0d want %0d 0", got.size(), bad, N);
      end
      check_poly("d1", 1);
   endtask

   task automatic test_d11_random();
      fill_random(44);
      run_poly(11, 44, 30, 60, -1);
      check_poly("d11", 11);
   endtask

   task automatic test_back_pressure();
      fill_random(48);
      run_poly(12, 48, 0, 100, 10);
      n_checks++;
      if (stall_cnt !== 6 || stall_stable !== 1'b1) begin
         n_fail++; $display("FAIL stall hold: cycles=%0d stable=%0b want 6 1", stall_cnt, stall_stable);
      end
      n_checks++;
      if (stall_drop !== 1'b1) begin
         n_fail++; $display("FAIL stall ready drop: got %0b want 1", stall_drop);
      end
      check_poly("stall", 12);
   endtask

   task automatic test_illegal_d();
      logic rdy_seen;
      @(posedge i_clk); #1;
      i_start = 1'b1; i_l = 4'd7;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      @(negedge i_clk);
      n_checks++;
      if (o_err !== 1'b1 || o_ibytes_ready !== 1'b0) begin
         n_fail++; $display("FAIL illegal d: err=%0b ready=%0b want 1 0", o_err, o_ibytes_ready);
      end
      rdy_seen = 1'b0;
      @(negedge i_clk);
      n_checks++;
      if (o_err !== 1'b0) begin
         n_fail++; $display("FAIL illegal err width: got %0b want 0", o_err);
      end
      repeat (3) begin
         @(negedge i_clk);
         if (o_ibytes_ready !== 1'b0) rdy_seen = 1'b1;
      end
      n_checks++;
      if (rdy_seen !== 1'b0) begin
         n_fail++; $display("FAIL illegal idle ready: got %0b want 0", rdy_seen);
      end
      fill_random(16);
      run_poly(4, 16, 20, 80, -1);
      check_poly("d4_after_err", 4);
   endtask

   task automatic test_reset_mid();
      int w;
      int cyc;
      fill_random(40);
      @(posedge i_clk); #1;
      i_start = 1'b1; i_l = 4'd10;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      i_coeffs_ready = 1'b1;
      w = 0; cyc = 0;
      while (w < 20 && cyc < 500) begin
         i_ibytes_valid = 1'b1;
         i_ibytes = words[w];
         @(negedge i_clk);
         if (o_ibytes_ready) w++;
         @(posedge i_clk); #1;
         cyc++;
      end
      n_checks++;
      if (w !== 20) begin
         n_fail++; $display("FAIL reset_mid words in: got %0d want 20", w);
      end
      i_ibytes_valid = 1'b0;
      i_coeffs_ready = 1'b0;
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      @(negedge i_clk);
      n_checks++;
      if ({o_ibytes_ready, o_coeffs_valid, o_done, o_err} !== 4'b0 || o_coeffs !== '0 || o_modq_flag !== '0) begin
         n_fail++;
         $display("FAIL reset_mid outputs: ctrl=%b coeffs=%h flags=%b want 0", {o_ibytes_ready, o_coeffs_valid, o_done, o_err}, o_coeffs, o_modq_flag);
      end
      fill_random(40);
      run_poly(10, 40, 10, 80, -1);
      check_poly("d10_after_rst", 10);
   endtask

   task automatic test_modq();
      logic [3:0] first;
      fill_random(48);
      words[0][47:0] = 48'h000FFFD01D00;
      run_poly(12, 48, 0, 100, -1);
      first = (got_flag.size() >= 4) ? {got_flag[3], got_flag[2], got_flag[1], got_flag[0]} : 4'bx;
      n_checks++;
`ifdef MODQ_CHECK_EN
      if (first !== 4'b0110) begin
         n_fail++; $display("FAIL modq first beat: got %b want 0110", first);
      end
`else
      if (first !== 4'b0000) begin
         n_fail++; $display("FAIL modq first beat: got %b want 0000", first);
      end
`endif
      check_poly("modq", 12);
   endtask

   initial begin
      test_reset();
      test_d12_bytes();
      test_d1_ones();
      test_d11_random();
      test_back_pressure();
      test_illegal_d();
      test_reset_mid();
      test_modq();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
